// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop RX synchroniser, oversampled mid-bit sampling FSM,
// LSB-first reassembly with optional parity, and a one-entry valid/ready holding register.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_m, rx_s;
  logic [DIV_WIDTH-1:0] div_q, div_cnt;
  logic [SW-1:0]        smp_cnt, smp_last;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tick, sample;
  logic                 par_bad, frm_bad, done_q;

  assign tick     = (div_cnt == div_q);
  assign smp_last = (state_q == START) ? SW'(OVERSAMPLE/2 - 1) : SW'(OVERSAMPLE - 1);
  assign sample   = tick && (smp_cnt == smp_last);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!rx_s) state_d = START;
      START:    if (sample) state_d = rx_s ? IDLE : DATA;
      DATA:     if (sample && bit_cnt == BW'(DATA_BITS - 1))
                  state_d = parity_en ? PARITY : STOP;
      PARITY:   if (sample) state_d = STOP;
      STOP:     if (sample) state_d = rx_s ? IDLE : BRK_WAIT;
      BRK_WAIT: if (rx_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      div_q      <= '0;
      div_cnt    <= '0;
      smp_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      done_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_m    <= RX;
      rx_s    <= rx_m;
      state_q <= state_d;

      // Divider and sample counter are parked at zero in IDLE so a frame
      // always starts its timing from the synchronised falling edge.
      if (state_q == IDLE) begin
        div_q   <= baud_div;
        div_cnt <= '0;
        smp_cnt <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        smp_cnt <= sample ? '0 : smp_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state_q == START && sample) par_bad <= 1'b0;
      if (state_q == DATA && sample) begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state_q == PARITY && sample) par_bad <= (rx_s != ((^shift_q) ^ parity_odd));
      if (state_q == STOP && sample) frm_bad <= !rx_s;

      done_q     <= (state_q == STOP) && sample;
      frame_err  <= done_q && frm_bad;
      parity_err <= done_q && par_bad;
      overrun    <= done_q && rx_valid && !rx_ready;

      // A completion may refill the register in the same cycle it is drained.
      if (done_q && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
